controle_jogada: RTL and testbench

- Moore FSM that sequences one play-round timer per round of the game.
- Drives the period counter's clear and count inputs and consumes its fim_antes/fim_depois flags.
- Requests the mid-period display update, and strobes the datapath to register and compare each player move.
- Keeps the round index and an accumulated score: 2 points for a correct move before the display update, 1 point after it, 0 on a wrong move or timeout.

---
 rtl/controle_jogada_pkg.sv | 25 ++
 rtl/controle_jogada_acumulador_pontos.sv | 28 ++
 rtl/controle_jogada.sv | 122 ++++++++++++
 tb/tb_controle_jogada.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/controle_jogada_pkg.sv
// Shared encodings for the play-round controller:
// state codes, point values and move phase.
package controle_jogada_pkg;

    typedef enum logic [3:0] {
        INICIAL       = 4'h0,
        PREPARACAO    = 4'h1,
        ESPERA_ANTES  = 4'h2,
        ATUALIZA      = 4'h3,
        ESPERA_DEPOIS = 4'h4,
        REGISTRA      = 4'h5,
        COMPARA       = 4'h6,
        PROXIMA       = 4'h7,
        FIM           = 4'hF
    } estado_t;

    typedef enum logic {
        FASE_ANTES  = 1'b0,
        FASE_DEPOIS = 1'b1
    } fase_t;

    localparam logic [1:0] PONTOS_ANTES  = 2'd2;
    localparam logic [1:0] PONTOS_DEPOIS = 2'd1;

endpackage

// File: rtl/controle_jogada_acumulador_pontos.sv
// Score register: sync clear, add enable and a
// 2-bit increment that saturates at all-ones.
module acumulador_pontos #(
    parameter int W = 6
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         zera,
    input  logic         soma,
    input  logic [1:0]   incremento,
    output logic [W-1:0] pontos
);

    localparam logic [W+1:0] MAXIMO = {2'b00, {W{1'b1}}};

    logic [W+1:0] total;

    assign total = {2'b00, pontos} + {{W{1'b0}}, incremento};

    // score update with saturation
    always_ff @(posedge clock) begin
        if (reset || zera)
            pontos <= '0;
        else if (soma)
            pontos <= (total > MAXIMO) ? {W{1'b1}} : total[W-1:0];
    end

endmodule

// File: rtl/controle_jogada.sv
// Moore FSM sequencing one timed play round per
// game round; keeps round index and score.
module controle_jogada
    import controle_jogada_pkg::*;
#(
    parameter int NUM_RODADAS = 16,
    parameter int W_RODADA    = 4,
    parameter int W_PONTOS    = 6
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                iniciar,
    input  logic                jogada,
    input  logic                acertou,
    input  logic                fim_antes,
    input  logic                fim_depois,
    output logic                zera_periodo,
    output logic                conta_periodo,
    output logic                atualiza_display,
    output logic                registra_jogada,
    output logic                timeout,
    output logic [W_RODADA-1:0] rodada,
    output logic [W_PONTOS-1:0] pontos,
    output logic                pronto,
    output logic [3:0]          db_estado
);

    estado_t             estado;
    estado_t             proximo;
    fase_t               fase;
    logic [W_RODADA-1:0] rodada_q;
    logic                timeout_q;
    logic                limpa;
    logic                ultima;
    logic                soma;
    logic [1:0]          incremento;

    assign ultima = (rodada_q == W_RODADA'(NUM_RODADAS - 1));
    assign limpa  = ((estado == INICIAL) || (estado == FIM)) && iniciar;

    // state register
    always_ff @(posedge clock) begin
        if (reset)
            estado <= INICIAL;
        else
            estado <= proximo;
    end

    // next-state logic; a move beats a coincident period flag
    always_comb begin
        proximo = estado;
        unique case (estado)
            INICIAL:       if (iniciar) proximo = PREPARACAO;
            PREPARACAO:    proximo = ESPERA_ANTES;
            ESPERA_ANTES: begin
                if (jogada)
                    proximo = REGISTRA;
                else if (fim_antes)
                    proximo = ATUALIZA;
            end
            ATUALIZA:      proximo = ESPERA_DEPOIS;
            ESPERA_DEPOIS: begin
                if (jogada)
                    proximo = REGISTRA;
                else if (fim_depois)
                    proximo = PROXIMA;
            end
            REGISTRA:      proximo = COMPARA;
            COMPARA:       proximo = PROXIMA;
            PROXIMA:       proximo = ultima ? FIM : PREPARACAO;
            FIM:           if (iniciar) proximo = PREPARACAO;
            default:       proximo = INICIAL;
        endcase
    end

    // move phase, round index and registered timeout pulse
    always_ff @(posedge clock) begin
        if (reset) begin
            fase      <= FASE_ANTES;
            rodada_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= (estado == ESPERA_DEPOIS)
                         && !jogada && fim_depois;
            if (limpa)
                rodada_q <= '0;
            else if ((estado == PROXIMA) && !ultima)
                rodada_q <= rodada_q + W_RODADA'(1);
            if ((estado == ESPERA_ANTES) && jogada)
                fase <= FASE_ANTES;
            else if ((estado == ESPERA_DEPOIS) && jogada)
                fase <= FASE_DEPOIS;
        end
    end

    assign soma       = (estado == COMPARA) && acertou;
    assign incremento = (fase == FASE_ANTES) ? PONTOS_ANTES
                                             : PONTOS_DEPOIS;

    acumulador_pontos #(
        .W(W_PONTOS)
    ) u_acumulador (
        .clock      (clock),
        .reset      (reset),
        .zera       (limpa),
        .soma       (soma),
        .incremento (incremento),
        .pontos     (pontos)
    );

    assign zera_periodo     = (estado == PREPARACAO);
    assign conta_periodo    = (estado == ESPERA_ANTES)
                              || (estado == ATUALIZA)
                              || (estado == ESPERA_DEPOIS);
    assign atualiza_display = (estado == ATUALIZA);
    assign registra_jogada  = (estado == REGISTRA);
    assign timeout          = timeout_q;
    assign rodada           = rodada_q;
    assign pronto           = (estado == FIM);
    assign db_estado        = estado;

endmodule

// File: tb/tb_controle_jogada.sv
// Directed bench with a score scoreboard; a second
// instance with a 3-bit score exercises saturation.
module tb_controle_jogada;

    localparam int NR = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       iniciar = 1'b0;
    logic       jogada = 1'b0;
    logic       acertou = 1'b0;
    logic       fim_antes = 1'b0;
    logic       fim_depois = 1'b0;

    logic       zera, conta, atual, regis, tmo, pronto;
    logic [1:0] rodada;
    logic [5:0] pontos;
    logic [3:0] db;

    logic       b_zera, b_conta, b_atual, b_regis, b_tmo, b_pronto;
    logic [1:0] b_rodada;
    logic [2:0] b_pontos;
    logic [3:0] b_db;

    int n_pass = 0;
    int n_chk  = 0;
    int q6[$];
    int q3[$];
    int e6   = 0;
    int e3   = 0;
    int erod = 0;

    always #5 clock = ~clock;

    controle_jogada #(
        .NUM_RODADAS(NR), .W_RODADA(2), .W_PONTOS(6)
    ) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar),
        .jogada(jogada), .acertou(acertou),
        .fim_antes(fim_antes), .fim_depois(fim_depois),
        .zera_periodo(zera), .conta_periodo(conta),
        .atualiza_display(atual), .registra_jogada(regis),
        .timeout(tmo), .rodada(rodada), .pontos(pontos),
        .pronto(pronto), .db_estado(db)
    );

    controle_jogada #(
        .NUM_RODADAS(NR), .W_RODADA(2), .W_PONTOS(3)
    ) dut_sat (
        .clock(clock), .reset(reset), .iniciar(iniciar),
        .jogada(jogada), .acertou(acertou),
        .fim_antes(fim_antes), .fim_depois(fim_depois),
        .zera_periodo(b_zera), .conta_periodo(b_conta),
        .atualiza_display(b_atual), .registra_jogada(b_regis),
        .timeout(b_tmo), .rodada(b_rodada), .pontos(b_pontos),
        .pronto(b_pronto), .db_estado(b_db)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic score(input int v);
        e6 = (e6 + v > 63) ? 63 : e6 + v;
        e3 = (e3 + v > 7) ? 7 : e3 + v;
        q6.push_back(e6);
        q3.push_back(e3);
    endtask

    task automatic check_score(input string tag);
        int x6, x3;
        chk({tag, "_qsz"}, q6.size(), 1);
        x6 = q6.pop_front();
        x3 = q3.pop_front();
        chk({tag, "_pontos"}, pontos, x6);
        chk({tag, "_pontos_sat"}, b_pontos, x3);
    endtask

    task automatic outs_zero(input string tag);
        chk(tag, {zera, conta, atual, regis, tmo, pronto,
                  rodada, pontos, b_pontos}, 0);
    endtask

    task automatic start_game(input string tag);
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        e6 = 0; e3 = 0; erod = 0;
        chk({tag, "_db"}, db, 1);
        chk({tag, "_zera"}, zera, 1);
        chk({tag, "_conta"}, conta, 0);
        chk({tag, "_rodada"}, rodada, 0);
        chk({tag, "_pontos"}, pontos, 0);
        step();
        chk({tag, "_zera_off"}, zera, 0);
    endtask

    // modes: 0 antes move, 1 depois move, 2 timeout,
    // 3 move with fim_antes, 4 move with fim_depois
    task automatic rodada_jogo(input int mode, input bit hit,
                               input string tag);
        chk({tag, "_ea"}, db, 2);
        chk({tag, "_conta"}, conta, 1);
        if (mode == 0 || mode == 3) begin
            jogada = 1'b1;
            acertou = hit;
            fim_antes = (mode == 3);
            score(hit ? 2 : 0);
            step();
            jogada = 1'b0;
            fim_antes = 1'b0;
            chk({tag, "_no_atual"}, atual, 0);
        end else begin
            repeat (3) step();
            fim_antes = 1'b1;
            step();
            fim_antes = 1'b0;
            chk({tag, "_at_db"}, db, 3);
            chk({tag, "_at_disp"}, atual, 1);
            chk({tag, "_at_conta"}, conta, 1);
            jogada = 1'b1;
            step();
            jogada = 1'b0;
            chk({tag, "_ed_db"}, db, 4);
            chk({tag, "_ed_disp"}, atual, 0);
            if (mode == 1) begin
                repeat (10) step();
                chk({tag, "_no_tmo"}, tmo, 0);
                jogada = 1'b1;
                acertou = hit;
                score(hit ? 1 : 0);
                step();
                jogada = 1'b0;
            end else if (mode == 4) begin
                repeat (2) step();
                jogada = 1'b1;
                fim_depois = 1'b1;
                acertou = hit;
                score(hit ? 1 : 0);
                step();
                jogada = 1'b0;
                fim_depois = 1'b0;
            end else begin
                repeat (5) step();
                fim_depois = 1'b1;
                score(0);
                step();
                fim_depois = 1'b0;
                chk({tag, "_to_db"}, db, 7);
                chk({tag, "_tmo"}, tmo, 1);
                check_score(tag);
            end
        end
        if (mode != 2) begin
            chk({tag, "_rg_db"}, db, 5);
            chk({tag, "_regis"}, regis, 1);
            chk({tag, "_rg_conta"}, conta, 0);
            chk({tag, "_rg_tmo"}, tmo, 0);
            step();
            chk({tag, "_cp_db"}, db, 6);
            step();
            acertou = 1'b0;
            chk({tag, "_px_db"}, db, 7);
            chk({tag, "_px_tmo"}, tmo, 0);
            check_score(tag);
        end
        if (erod == NR - 1) begin
            step();
            chk({tag, "_fim_db"}, db, 15);
            chk({tag, "_pronto"}, pronto, 1);
            chk({tag, "_fim_rod"}, rodada, erod);
        end else begin
            erod++;
            step();
            chk({tag, "_pp_db"}, db, 1);
            chk({tag, "_pp_zera"}, zera, 1);
            chk({tag, "_pp_tmo"}, tmo, 0);
            chk({tag, "_pp_rod"}, rodada, erod);
            step();
        end
    endtask

    initial begin
        repeat (2) step();
        chk("rst_db", db, 0);
        outs_zero("rst_outs");
        reset = 1'b0;
        step();
        chk("idle_db", db, 0);
        outs_zero("idle_outs");

        start_game("g1");
        rodada_jogo(0, 1'b1, "g1r0");
        rodada_jogo(1, 1'b1, "g1r1");
        rodada_jogo(2, 1'b0, "g1r2");
        rodada_jogo(3, 1'b1, "g1r3");
        step();
        chk("g1_hold_db", db, 15);
        chk("g1_hold_pts", pontos, 5);

        start_game("g2");
        rodada_jogo(4, 1'b1, "g2r0");
        rodada_jogo(0, 1'b0, "g2r1");
        rodada_jogo(0, 1'b1, "g2r2");
        rodada_jogo(1, 1'b0, "g2r3");

        start_game("g3");
        for (int i = 0; i < NR; i++)
            rodada_jogo(0, 1'b1, $sformatf("g3r%0d", i));
        chk("g3_total", pontos, 8);
        chk("g3_sat", b_pontos, 7);
        chk("g3_sat_pronto", b_pronto, 1);

        start_game("g4");
        repeat (2) step();
        fim_antes = 1'b1;
        step();
        fim_antes = 1'b0;
        step();
        chk("g4_ed_db", db, 4);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("g4_rst_db", db, 0);
        chk("g4_rst_db_sat", b_db, 0);
        outs_zero("g4_rst_outs");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
